// File: rtl/delay_block_sched.sv
// Address/shift sequencer for the inter-stage delay block RAM (LENGTH+2 slot ring).
// Optional drain input `flush` is compiled in when DBS_FLUSH_EN is defined.
module delay_block_sched #(
    parameter int LENGTH     = 6,
    parameter int BLOCK_SIZE = 512,
    parameter int AW         = $clog2(BLOCK_SIZE),
    parameter int SW         = $clog2(LENGTH + 2),
    parameter int OW         = $clog2(LENGTH + 3)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] addr_wr,
    input  logic          out_ready,
    output logic [AW-1:0] addr_rd,
    output logic          out_valid,
    output logic          out_last,
    output logic          shift,
    output logic [SW-1:0] epoch,
    output logic [OW-1:0] occupancy
`ifdef DBS_FLUSH_EN
    ,
    input  logic          flush
`endif
);

    localparam int NSLOT = LENGTH + 2;
    localparam logic [AW-1:0] LAST_IDX  = AW'(BLOCK_SIZE - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(LENGTH + 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [AW-1:0]    wr_cnt;
    logic [AW-1:0]    rd_cnt;
    logic             wr_done;
    logic             rd_done;
    logic             wr_blk;
    logic [NSLOT-1:0] vld;
    logic [NSLOT-1:0] vld_next;
    logic [OW-1:0]    occ_next;
    logic [SW-1:0]    rs;
    logic             flush_req;
    logic             flush_take;
    logic             rd_active;
    logic             last_wr;
    logic             issue;
    logic             last_rd;
    logic             wr_side_done;
    logic             rd_side_done;

`ifdef DBS_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Handshakes: a word moves when valid and ready are both high in the same cycle
    // (we = in_valid & in_ready); a read issues when out_ready is high and data follows one cycle later.
    assign rs           = (epoch == LAST_SLOT) ? '0 : epoch + 1'b1;
    assign rd_active    = vld[rs];
    assign flush_take   = (state == ST_RUN) & flush_req & ~wr_done & (wr_cnt == '0);
    assign in_ready     = (state == ST_RUN) & ~wr_done & ~flush_take;
    assign we           = in_valid & in_ready;
    assign last_wr      = we & (wr_cnt == LAST_IDX);
    assign issue        = (state == ST_RUN) & rd_active & ~rd_done & out_ready;
    assign last_rd      = issue & (rd_cnt == LAST_IDX);
    assign wr_side_done = wr_done | last_wr | flush_take;
    assign rd_side_done = ~rd_active | rd_done | last_rd;

    assign shift   = (state == ST_SHIFT);
    assign addr_wr = wr_cnt;
    assign addr_rd = rd_cnt;

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (wr_side_done && rd_side_done) state_next = ST_SHIFT;
            ST_SHIFT: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // Slot bookkeeping applied at the shift: the slot just read is freed, the slot just written
    // becomes valid only if a real block went into it.
    always_comb begin
        vld_next        = vld;
        vld_next[rs]    = 1'b0;
        vld_next[epoch] = wr_blk;
        occ_next        = '0;
        for (int i = 0; i < NSLOT; i++) begin
            occ_next = occ_next + OW'(vld_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            epoch     <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            wr_blk    <= 1'b0;
            vld       <= '0;
            occupancy <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= issue;
            out_last  <= last_rd;
            if (state == ST_SHIFT) begin
                vld       <= vld_next;
                occupancy <= occ_next;
                epoch     <= rs;
                wr_cnt    <= '0;
                rd_cnt    <= '0;
                wr_done   <= 1'b0;
                rd_done   <= 1'b0;
                wr_blk    <= 1'b0;
            end else begin
                if (we) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
                if (last_wr) begin
                    wr_done <= 1'b1;
                    wr_blk  <= 1'b1;
                end
                if (flush_take) begin
                    wr_done <= 1'b1;
                end
                if (issue) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (last_rd) begin
                    rd_done <= 1'b1;
                end
            end
        end
    end

endmodule
